hazard_control_unit: RTL and testbench

Pipeline hazard controller for the five-stage core. It owns the execute-stage ALU/MUL unit's multi-cycle sequencing for MUL and DIV operations. It detects load-use hazards between decode and execute, and produces the stall and flush controls for the F, D and E pipeline registers. It sits beside the execute-stage operand forwarding logic: forwarding covers result-ready hazards, and this block covers the cases forwarding cannot resolve.

---
 rtl/hazard_control_unit_pkg.sv | 26 ++
 rtl/hazard_control_unit_muldiv_sequencer.sv | 76 +++++++
 rtl/hazard_control_unit.sv | 91 +++++++++
 tb/tb_hazard_control_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg
//   Shared definitions for the pipeline hazard controller: sequencer state
//   encoding, register-address width, the x0 constant, default MUL/DIV
//   occupancies and a small register-dependency helper.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } hc_state_t;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0     = '0;

  localparam int MUL_CYCLES_DEFAULT = 4;
  localparam int DIV_CYCLES_DEFAULT = 33;

  // True when a producer rd feeds a consumer rs; x0 is hard-wired to zero
  // and so never carries a dependency.
  function automatic logic reg_dep(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_muldiv_sequencer.sv
// muldiv_sequencer
//   Tracks execute-stage occupancy of a multi-cycle MUL/DIV op.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     start    : an op is present in E (only acted on while IDLE)
//     is_div   : selects DIV_CYCLES at start, otherwise MUL_CYCLES
//     busy     : start cycle (combinational) and every BUSY cycle
//     done     : one-cycle pulse in the DONE state
module muldiv_sequencer
  import hazard_control_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  // The counter is loaded with LAT-1 on the start cycle so that BUSY lasts
  // LAT-1 cycles: together with the start cycle that is LAT stalled cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hc_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy    = 1'b1;
          state_d = BUSY;
          // Latency is latched here; is_div is not looked at again.
          cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // start still reflects the finishing op, so it is ignored here.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Stall/flush controller for the five-stage core. Covers the hazards
//   forwarding cannot: multi-cycle MUL/DIV occupancy of E, load-use
//   dependencies between D and E, and taken-branch squashing.
//   Ports:
//     clk, rst                         : clock, synchronous active-high reset
//     reg_readaddress1_d/2_d           : rs1/rs2 of the decode instruction
//     reg_writeaddress_e, mem_read_e   : rd of execute, execute is a load
//     muldiv_op_e, muldiv_is_div_e     : execute is MUL/DIV/REM, DIV latency
//     branch_taken_e                   : taken branch/jump resolved in E
//     muldiv_busy, muldiv_done         : sequencer occupancy / completion pulse
//     stall_f, stall_d, stall_e        : hold PC / F-D / D-E registers
//     flush_d, flush_e                 : bubble into F-D / D-E registers
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] reg_readaddress1_d,
  input  logic [REG_ADDR_W-1:0] reg_readaddress2_d,
  input  logic [REG_ADDR_W-1:0] reg_writeaddress_e,
  input  logic                  mem_read_e,
  input  logic                  muldiv_op_e,
  input  logic                  muldiv_is_div_e,
  input  logic                  branch_taken_e,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e
);

  logic seq_busy;
  logic seq_done;
  logic load_use;

  muldiv_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (muldiv_op_e),
    .is_div (muldiv_is_div_e),
    .busy   (seq_busy),
    .done   (seq_done)
  );

  // The load result is not available until M, so a dependent decode
  // instruction must wait one cycle; forwarding cannot close this gap.
  assign load_use = mem_read_e &&
                    (reg_dep(reg_writeaddress_e, reg_readaddress1_d) ||
                     reg_dep(reg_writeaddress_e, reg_readaddress2_d));

  // Priority: MUL/DIV occupancy freezes the whole front end and must not
  // squash the op in E, so it masks both branch flush and load-use.
  always_comb begin
    muldiv_busy = 1'b0;
    muldiv_done = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    if (!rst) begin
      muldiv_done = seq_done;
      if (seq_busy) begin
        muldiv_busy = 1'b1;
        stall_f     = 1'b1;
        stall_d     = 1'b1;
        stall_e     = 1'b1;
      end else if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        // Hold F and D, let the load move on, and bubble E behind it.
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int MUL_C = 4;
  localparam int DIV_C = 33;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ra1, ra2, wa;
  logic       mem_read, op, is_div, br;
  logic       busy, done, sf, sd, se, fd, fe;

  int errors = 0;
  int checks = 0;

  // Expected output vector: {busy, done, stall_f, stall_d, stall_e, flush_d, flush_e}
  typedef struct {
    logic [6:0] exp;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model: how many more occupied cycles follow the current one,
  // and whether the next cycle is the completion cycle.
  int  occ_left  = 0;
  bit  done_next = 0;
  int  cyc       = 0;
  bit  stim_done = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .MUL_CYCLES (MUL_C),
    .DIV_CYCLES (DIV_C),
    .CNT_W      (6)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .reg_readaddress1_d (ra1),
    .reg_readaddress2_d (ra2),
    .reg_writeaddress_e (wa),
    .mem_read_e         (mem_read),
    .muldiv_op_e        (op),
    .muldiv_is_div_e    (is_div),
    .branch_taken_e     (br),
    .muldiv_busy        (busy),
    .muldiv_done        (done),
    .stall_f            (sf),
    .stall_d            (sd),
    .stall_e            (se),
    .flush_d            (fd),
    .flush_e            (fe)
  );

  task automatic drive(input bit r, input bit o, input bit dv, input bit mr,
                       input bit b, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] w);
    exp_t e;
    bit   in_occ, exp_done, lu;
    @(posedge clk);
    #1;
    rst = r; op = o; is_div = dv; mem_read = mr; br = b;
    ra1 = a1; ra2 = a2; wa = w;
    cyc++;
    in_occ   = 0;
    exp_done = 0;
    if (r) begin
      occ_left  = 0;
      done_next = 0;
    end else if (done_next) begin
      exp_done  = 1;
      done_next = 0;
    end else if (occ_left > 0) begin
      in_occ = 1;
      occ_left--;
      if (occ_left == 0) done_next = 1;
    end else if (o) begin
      in_occ   = 1;
      occ_left = (dv ? DIV_C : MUL_C) - 1;
    end
    lu = mr && (w != 0) && (w == a1 || w == a2);
    e.cyc = cyc;
    e.exp = '0;
    if (!r) begin
      e.exp[5] = exp_done;
      if (in_occ)  e.exp = {1'b1, 1'b0, 3'b111, 2'b00};
      else if (b)  e.exp[1:0] = 2'b11;
      else if (lu) begin
        e.exp[4:3] = 2'b11;
        e.exp[0]   = 1'b1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {busy, done, sf, sd, se, fd, fe};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b (busy,done,sf,sd,se,fd,fe)",
                 e.cyc, act, e.exp);
      end
    end
  end

  initial begin
    rst = 1; op = 0; is_div = 0; mem_read = 0; br = 0; ra1 = 0; ra2 = 0; wa = 0;
    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 5'd7, 5'd7, 5'd7);
    idle_cycles(2);
    // Single MUL, op held until it leaves E
    for (int i = 0; i < MUL_C + 1; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle_cycles(2);
    // DIV with is_div toggling mid-op
    for (int i = 0; i < DIV_C + 1; i++) drive(0, 1, (i == 0) ? 1'b1 : i[0], 0, 0, 0, 0, 0);
    idle_cycles(2);
    // Load-use on rs2, on rs1, and the x0 exemption
    drive(0, 0, 0, 1, 0, 5'd3, 5'd7, 5'd7);
    drive(0, 0, 0, 1, 0, 5'd9, 5'd4, 5'd9);
    drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7);
    // Branch alone, branch over load-use, branch with MUL start
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd5);
    for (int i = 0; i < MUL_C + 1; i++) drive(0, 1, 0, 0, 1, 0, 0, 0);
    // Back-to-back MULs with op held continuously
    for (int i = 0; i < 2 * (MUL_C + 1); i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    // Load and MUL together: MUL wins
    for (int i = 0; i < MUL_C + 1; i++) drive(0, 1, 0, 1, 0, 5'd6, 5'd6, 5'd6);
    idle_cycles(1);
    // Reset two cycles into a DIV: no done pulse afterwards
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle_cycles(DIV_C + 2);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)));
    end
    idle_cycles(2);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    stim_done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    if (!stim_done) begin
      $display("FAIL watchdog: run exceeded time limit, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
